aud_player_i2s: RTL and testbench

//   Playback counterpart of the recorder: reads 16-bit mono samples from SRAM and

---
 rtl/aud_player_i2s.sv | 207 ++++++++++++++++++++
 tb/tb_aud_player_i2s.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aud_player_i2s.sv
// I2S playback engine: fetches 16-bit mono samples from SRAM and
// shifts them out to a WM8731 DAC that masters BCLK/DACLRCK.
module aud_player_i2s #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int SRAM_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_bclk,
  input  logic              i_daclrck,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic [DATA_W-1:0] i_sram_data,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_rd_en,
  output logic              o_dacdat,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int LAT_W = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(SRAM_LAT - 1);
  localparam logic [CNT_W-1:0] BITS = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PLAY,
    S_PAUSE
  } state_t;

  state_t state_q, state_d;

  logic [2:0]        bclk_q, lrc_q;
  logic              bclk_fall, lrc_fall, lrc_rise;
  logic [ADDR_W-1:0] end_q;
  logic [DATA_W-1:0] next_buf, cur_smp, shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic              fetching, fetch_last;
  logic              last_flag, pause_req;
  logic              do_start, do_load, do_done;
  logic              pause_xit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bclk_q <= '0;
      lrc_q  <= '0;
    end else begin
      bclk_q <= {bclk_q[1:0], i_bclk};
      lrc_q  <= {lrc_q[1:0], i_daclrck};
    end
  end

  assign bclk_fall  = bclk_q[2] & ~bclk_q[1];
  assign lrc_fall   = lrc_q[2] & ~lrc_q[1];
  assign lrc_rise   = ~lrc_q[2] & lrc_q[1];
  assign fetch_last = fetching && (lat_cnt == LAT_LAST);

  assign o_rd_en = fetching;
  assign o_busy  = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    do_start  = 1'b0;
    do_load   = 1'b0;
    do_done   = 1'b0;
    pause_xit = 1'b0;
    if (i_stop) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_d  = S_FETCH;
            do_start = 1'b1;
          end
        end
        S_FETCH: begin
          if (fetch_last) state_d = S_PLAY;
        end
        S_PLAY: begin
          if (lrc_fall) begin
            if (last_flag) begin
              state_d = S_IDLE;
              do_done = 1'b1;
            end else if (pause_req) begin
              state_d   = S_PAUSE;
              pause_xit = 1'b1;
            end else begin
              do_load = 1'b1;
            end
          end
        end
        S_PAUSE: begin
          if (lrc_fall && pause_req) begin
            pause_xit = 1'b1;
            if (last_flag) begin
              state_d = S_IDLE;
              do_done = 1'b1;
            end else begin
              state_d = S_PLAY;
              do_load = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      o_address <= '0;
      end_q     <= '0;
      next_buf  <= '0;
      cur_smp   <= '0;
      lat_cnt   <= '0;
      fetching  <= 1'b0;
      last_flag <= 1'b0;
      pause_req <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state_q <= state_d;
      o_done  <= do_done;

      if (fetching) begin
        if (lat_cnt == LAT_LAST) begin
          fetching <= 1'b0;
          lat_cnt  <= '0;
          next_buf <= i_sram_data;
        end else begin
          lat_cnt <= lat_cnt + LAT_W'(1);
        end
      end

      if (do_start) begin
        fetching  <= 1'b1;
        lat_cnt   <= '0;
        o_address <= '0;
        end_q     <= i_end_addr;
        last_flag <= 1'b0;
        cur_smp   <= '0;
      end

      // Consume the buffered sample and prefetch its successor
      if (do_load) begin
        cur_smp <= next_buf;
        if (o_address == end_q) begin
          last_flag <= 1'b1;
        end else begin
          o_address <= o_address + ADDR_W'(1);
          fetching  <= 1'b1;
          lat_cnt   <= '0;
        end
      end

      if (pause_xit) begin
        pause_req <= 1'b0;
      end else if (i_pause &&
                   (state_q == S_PLAY ||
                    state_q == S_PAUSE)) begin
        pause_req <= ~pause_req;
      end

      if (state_d == S_IDLE) begin
        o_address <= '0;
        fetching  <= 1'b0;
        lat_cnt   <= '0;
        last_flag <= 1'b0;
        pause_req <= 1'b0;
      end
    end
  end

  // Shifter runs in every busy state; only PLAY lets bits reach the pin
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      o_dacdat <= 1'b0;
    end else if (state_d == S_IDLE) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      o_dacdat <= 1'b0;
    end else if (lrc_fall || lrc_rise) begin
      shreg    <= do_load ? next_buf : cur_smp;
      bit_cnt  <= '0;
      o_dacdat <= 1'b0;
    end else if (bclk_fall) begin
      if (bit_cnt < BITS) begin
        o_dacdat <= (state_q == S_PLAY) &
                    shreg[DATA_W-1];
        shreg    <= {shreg[DATA_W-2:0], 1'b0};
        bit_cnt  <= bit_cnt + CNT_W'(1);
      end else begin
        o_dacdat <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aud_player_i2s.sv
// Directed bench for aud_player_i2s: I2S frame capture against
// hand-computed slot patterns, transport control and termination.
module tb_aud_player_i2s;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic bclk = 1'b0;
  logic lrc  = 1'b1;
  int   bcnt = 39;

  logic        start1 = 1'b0, pause1 = 1'b0, stop1 = 1'b0;
  logic [19:0] end1 = '0;
  logic [15:0] sdat1;
  logic [19:0] addr1;
  logic        rden1, dac1, busy1, done1;

  logic        start3 = 1'b0, pause3 = 1'b0, stop3 = 1'b0;
  logic [19:0] end3 = '0;
  logic [15:0] sdat3;
  logic [19:0] addr3;
  logic        rden3, dac3, busy3, done3;

  logic [15:0] mem1 [16];
  logic [15:0] mem3 [16];

  int n_vec = 0;
  int n_err = 0;
  int done1_cnt = 0, done3_cnt = 0;
  int rd1_cnt = 0, rd3_cnt = 0;

  aud_player_i2s u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_bclk      (bclk),
    .i_daclrck   (lrc),
    .i_start     (start1),
    .i_pause     (pause1),
    .i_stop      (stop1),
    .i_end_addr  (end1),
    .i_sram_data (sdat1),
    .o_address   (addr1),
    .o_rd_en     (rden1),
    .o_dacdat    (dac1),
    .o_busy      (busy1),
    .o_done      (done1)
  );

  aud_player_i2s #(.SRAM_LAT(3)) u_dut3 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_bclk      (bclk),
    .i_daclrck   (lrc),
    .i_start     (start3),
    .i_pause     (pause3),
    .i_stop      (stop3),
    .i_end_addr  (end3),
    .i_sram_data (sdat3),
    .o_address   (addr3),
    .o_rd_en     (rden3),
    .o_dacdat    (dac3),
    .o_busy      (busy3),
    .o_done      (done3)
  );

  assign sdat1 = (rden1 && addr1 < 20'd16) ?
                 mem1[addr1[3:0]] : 16'hDEAD;
  assign sdat3 = (rden3 && addr3 < 20'd16) ?
                 mem3[addr3[3:0]] : 16'hDEAD;

  always #5 clk = ~clk;

  // BCLK = clk/8, 20 BCLKs per slot, LRC moves on BCLK fall
  always begin
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    repeat (4) @(negedge clk);
    bclk = 1'b0;
    bcnt = (bcnt == 39) ? 0 : bcnt + 1;
    if (bcnt == 0) lrc = 1'b0;
    else if (bcnt == 20) lrc = 1'b1;
  end

  always @(negedge clk) begin
    if (done1) done1_cnt <= done1_cnt + 1;
    if (done3) done3_cnt <= done3_cnt + 1;
    if (rden1) rd1_cnt <= rd1_cnt + 1;
    if (rden3) rd3_cnt <= rd3_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [2:0] v,
                       input bit d3);
    @(negedge clk);
    if (d3) {start3, pause3, stop3} = v;
    else    {start1, pause1, stop1} = v;
    @(negedge clk);
    {start1, pause1, stop1} = 3'b000;
    {start3, pause3, stop3} = 3'b000;
  endtask

  task automatic sync_mid();
    @(posedge lrc);
    repeat (4) @(negedge clk);
  endtask

  task automatic cap_frame(input bit d3,
                           output logic [19:0] l,
                           output logic [19:0] r);
    l = '0;
    r = '0;
    @(negedge lrc);
    repeat (20) begin
      @(posedge bclk);
      l = {l[18:0], d3 ? dac3 : dac1};
    end
    repeat (20) begin
      @(posedge bclk);
      r = {r[18:0], d3 ? dac3 : dac1};
    end
  endtask

  task automatic chk_frame(input string tag,
                           input bit d3,
                           input logic [15:0] smp);
    logic [19:0] l, r, e;
    cap_frame(d3, l, r);
    e = {1'b0, smp, 3'b000};
    chk({tag, "_l"}, 32'(l), 32'(e));
    chk({tag, "_r"}, 32'(r), 32'(e));
  endtask

  task automatic wait_done(input bit d3, input int want);
    for (int i = 0; i < 80; i++) begin
      if ((d3 ? done3_cnt : done1_cnt) >= want) break;
      @(negedge clk);
    end
  endtask

  initial begin
    int d0, r0;
    for (int i = 0; i < 16; i++) begin
      mem1[i] = '0;
      mem3[i] = '0;
    end

    // reset with clocks toggling
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dac",  32'(dac1),  32'd0);
    chk("rst_addr", 32'(addr1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_rden", 32'(rden1), 32'd0);
    chk("rst_busy3", 32'(busy3), 32'd0);
    rst = 1'b0;

    // three-sample playback
    mem1[0] = 16'hA5C3;
    mem1[1] = 16'h8001;
    mem1[2] = 16'h7FFE;
    end1 = 20'd2;
    sync_mid();
    d0 = done1_cnt;
    r0 = rd1_cnt;
    pulse(3'b100, 1'b0);
    chk("t2_busy", 32'(busy1), 32'd1);
    chk("t2_rden", 32'(rden1), 32'd1);
    chk_frame("t2_s0", 1'b0, 16'hA5C3);
    chk("t2_a0", 32'(addr1), 32'd1);
    chk_frame("t2_s1", 1'b0, 16'h8001);
    chk("t2_a1", 32'(addr1), 32'd2);
    chk_frame("t2_s2", 1'b0, 16'h7FFE);
    chk("t2_a2", 32'(addr1), 32'd2);
    chk("t2_early", 32'(done1_cnt - d0), 32'd0);
    wait_done(1'b0, d0 + 1);
    chk("t2_done", 32'(done1_cnt - d0), 32'd1);
    chk("t2_idle", 32'(busy1), 32'd0);
    chk("t2_addr", 32'(addr1), 32'd0);
    chk("t2_rdcyc", 32'(rd1_cnt - r0), 32'd6);
    chk_frame("t2_quiet", 1'b0, 16'h0000);
    chk("t2_once", 32'(done1_cnt - d0), 32'd1);

    // stop in the middle of the left slot
    sync_mid();
    d0 = done1_cnt;
    pulse(3'b100, 1'b0);
    @(negedge lrc);
    repeat (2) @(posedge bclk);
    chk("t4_msb", 32'(dac1), 32'd1);
    pulse(3'b001, 1'b0);
    chk("t4_busy", 32'(busy1), 32'd0);
    chk("t4_dac", 32'(dac1), 32'd0);
    chk("t4_addr", 32'(addr1), 32'd0);
    chk_frame("t4_quiet", 1'b0, 16'h0000);
    chk("t4_nodone", 32'(done1_cnt - d0), 32'd0);

    // start+stop in IDLE, then pause+stop in PLAY
    sync_mid();
    d0 = done1_cnt;
    pulse(3'b101, 1'b0);
    chk("t5_busy", 32'(busy1), 32'd0);
    chk("t5_rden", 32'(rden1), 32'd0);
    repeat (5) @(negedge clk);
    chk("t5_stay", 32'(busy1), 32'd0);
    pulse(3'b100, 1'b0);
    chk_frame("t5_s0", 1'b0, 16'hA5C3);
    pulse(3'b011, 1'b0);
    chk("t5_pbusy", 32'(busy1), 32'd0);
    chk("t5_paddr", 32'(addr1), 32'd0);
    chk("t5_pdac", 32'(dac1), 32'd0);
    chk_frame("t5_quiet", 1'b0, 16'h0000);
    chk("t5_nodone", 32'(done1_cnt - d0), 32'd0);

    // pause for five frames during a four-sample clip
    mem1[0] = 16'h1234;
    mem1[1] = 16'h8F0F;
    mem1[2] = 16'h4C21;
    mem1[3] = 16'hF00D;
    end1 = 20'd3;
    sync_mid();
    d0 = done1_cnt;
    pulse(3'b100, 1'b0);
    chk_frame("t3_s0", 1'b0, 16'h1234);
    chk_frame("t3_s1", 1'b0, 16'h8F0F);
    pulse(3'b010, 1'b0);
    for (int f = 0; f < 5; f++) begin
      chk_frame("t3_pz", 1'b0, 16'h0000);
      if (f == 0) chk("t3_paddr", 32'(addr1), 32'd2);
    end
    chk("t3_pbusy", 32'(busy1), 32'd1);
    pulse(3'b010, 1'b0);
    chk_frame("t3_s2", 1'b0, 16'h4C21);
    chk_frame("t3_s3", 1'b0, 16'hF00D);
    chk("t3_early", 32'(done1_cnt - d0), 32'd0);
    wait_done(1'b0, d0 + 1);
    chk("t3_done", 32'(done1_cnt - d0), 32'd1);
    chk("t3_idle", 32'(busy1), 32'd0);

    // single sample, SRAM latency 3
    mem3[0] = 16'h5AF0;
    mem3[1] = 16'h0FF0;
    end3 = 20'd0;
    sync_mid();
    d0 = done3_cnt;
    r0 = rd3_cnt;
    pulse(3'b100, 1'b1);
    chk("t6_busy", 32'(busy3), 32'd1);
    chk_frame("t6_s0", 1'b1, 16'h5AF0);
    chk("t6_early", 32'(done3_cnt - d0), 32'd0);
    wait_done(1'b1, d0 + 1);
    chk("t6_done", 32'(done3_cnt - d0), 32'd1);
    chk("t6_idle", 32'(busy3), 32'd0);
    chk("t6_rdcyc", 32'(rd3_cnt - r0), 32'd3);
    chk_frame("t6_quiet", 1'b1, 16'h0000);
    chk("t6_once", 32'(done3_cnt - d0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
